// File: rtl/to_sw_pkg.sv
// Shared field layout of the to_sw status/payload word and a helper that packs it.
package to_sw_pkg;

  localparam int VALID_BIT     = 31;
  localparam int OVF_BIT       = 30;
  localparam int SEQ_LSB       = 24;
  localparam int SEQ_W         = 6;
  localparam int OCC_LSB       = 20;
  localparam int OCC_W         = 4;
  localparam int PAYLOAD_W_MAX = 16;

  // Assemble the software-visible word; bits [19:16] are always zero.
  function automatic logic [31:0] pack_word(
    input logic                     valid,
    input logic                     ovf,
    input logic [SEQ_W-1:0]         seq,
    input logic [OCC_W-1:0]         occ,
    input logic [PAYLOAD_W_MAX-1:0] payload
  );
    logic [31:0] word;
    word                              = 32'h0000_0000;
    word[VALID_BIT]                   = valid;
    word[OVF_BIT]                     = ovf;
    word[SEQ_LSB +: SEQ_W]            = seq;
    word[OCC_LSB +: OCC_W]            = occ;
    word[PAYLOAD_W_MAX-1:0]           = payload;
    return word;
  endfunction

endpackage

// File: rtl/to_sw_sync_fifo.sv
// Register-based FIFO. Head and the entry behind it are read combinationally so
// the top level can compute the next head word without a RAM read latency.
// The caller guarantees push only when !full and pop only when !empty.
module to_sw_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_second,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state pointers and occupancy; pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Pointer, count and storage registers; reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

  assign dout        = mem_q[rd_ptr_q];
  assign dout_second = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == CNT_W'(0));

endmodule

// File: rtl/nios_system_to_sw_event_queue.sv
// Event queue feeding the to_sw PIO: buffers event pulses and presents the head
// entry plus status as one registered word. A level change on sw_ack_toggle pops.
module nios_system_to_sw_event_queue
  import to_sw_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 evt_valid,
  input  logic [PAYLOAD_W-1:0] evt_data,
  output logic                 evt_ready,
  input  logic                 sw_ack_toggle,
  output logic [31:0]          to_sw_word,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 ack_q;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          word_q, word_d;

  logic                 ack_edge;
  logic                 push, pop, drop;
  logic [CNT_W-1:0]     count_d;
  logic [PAYLOAD_W-1:0] head_d;

  logic [PAYLOAD_W-1:0] fifo_head, fifo_second;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;

  to_sw_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push        (push),
    .pop         (pop),
    .din         (evt_data),
    .dout        (fifo_head),
    .dout_second (fifo_second),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Decode push/drop/pop and build the next word from next-state values, so a
  // change is visible one edge after the causing event.
  always_comb begin
    ack_edge = sw_ack_toggle ^ ack_q;
    push     = evt_valid && !fifo_full;
    drop     = evt_valid && fifo_full;
    pop      = ack_edge && !fifo_empty;
    count_d  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    seq_d    = seq_q + SEQ_W'(pop);
    head_d   = '0;
    if (count_d == CNT_W'(0)) begin
      head_d = '0;
    end else if (!pop) begin
      // No pop: head stays, unless this push lands in an empty FIFO.
      head_d = fifo_empty ? evt_data : fifo_head;
    end else if (fifo_count == CNT_W'(1)) begin
      // Last entry popped while a push arrives: the new event becomes head.
      head_d = evt_data;
    end else begin
      head_d = fifo_second;
    end
    // A drop wins over a clearing ack in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ack_edge) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    word_d = pack_word(count_d != CNT_W'(0), ovf_d, seq_d, OCC_W'(count_d),
                       PAYLOAD_W_MAX'(head_d));
  end

  // Ack history, sequence counter, sticky overflow and the output word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      word_q <= 32'h0000_0000;
    end else begin
      ack_q  <= sw_ack_toggle;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      word_q <= word_d;
    end
  end

  assign evt_ready  = !fifo_full;
  assign to_sw_word = word_q;
  assign overflow   = ovf_q;

endmodule
